// File: rtl/pmp_csr_regfile_pkg.sv
// Core configuration type and RISC-V PMP definitions shared by the PMP CSR
// register file, its per-entry registers and the PMP checkers.
package config_pkg;

  typedef struct packed {
    int unsigned       NrPMPEntries;
    logic [15:0][63:0] PMPCfgRstVal;
    logic [15:0][63:0] PMPAddrRstVal;
    logic [15:0]       PMPEntryReadOnly;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_default = '{
    NrPMPEntries:     32'd8,
    PMPCfgRstVal:     '0,
    PMPAddrRstVal:    '0,
    PMPEntryReadOnly: '0
  };

endpackage

package riscv_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  // Reserved bits 6:5 are hardwired to zero in every stored cfg byte.
  function automatic pmpcfg_t pmpcfg_legalize(input logic [7:0] b);
    return pmpcfg_t'(b & 8'h9F);
  endfunction

  // W=1 with R=0 is a reserved combination; such a write leaves the byte alone.
  function automatic logic pmpcfg_is_reserved(input logic [7:0] b);
    return b[1] & ~b[0];
  endfunction

endpackage

// File: rtl/pmp_csr_regfile_entry.sv
// One PMP entry: config byte and address register with WARL legalisation,
// sticky lock and TOR lock from the entry above.
module pmp_entry_reg
  import riscv_pkg::*;
#(
  parameter logic [7:0]  CfgRstVal  = 8'h00,
  parameter logic [31:0] AddrRstVal = 32'h0,
  parameter bit          ReadOnly   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_we,
  input  logic [7:0]  i_cfg_wdata,
  input  logic        i_addr_we,
  input  logic [31:0] i_addr_wdata,
  input  logic        i_next_tor_lock,
  output pmpcfg_t     o_cfg,
  output logic [31:0] o_addr,
  output logic        o_tor_lock
);

  pmpcfg_t     r_cfg;
  logic [31:0] r_addr;
  logic        w_cfg_ok;
  logic        w_addr_ok;

  // Both decisions use the pre-write lock, so a lock set now only binds later requests.
  assign w_cfg_ok  = !ReadOnly && !r_cfg.locked && !pmpcfg_is_reserved(i_cfg_wdata);
  assign w_addr_ok = !ReadOnly && !r_cfg.locked && !i_next_tor_lock;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg  <= pmpcfg_legalize(CfgRstVal);
      r_addr <= AddrRstVal;
    end else begin
      if (i_cfg_we && w_cfg_ok) begin
        r_cfg <= pmpcfg_legalize(i_cfg_wdata);
      end
      if (i_addr_we && w_addr_ok) begin
        r_addr <= i_addr_wdata;
      end
    end
  end

  assign o_cfg      = r_cfg;
  assign o_addr     = r_addr;
  assign o_tor_lock = r_cfg.locked && (r_cfg.addr_mode == TOR);

endmodule

// File: rtl/pmp_csr_regfile.sv
// Machine-mode PMP configuration/address CSR file feeding the PMP checkers.
// Handshake: csr_req_i has no ready; every request is accepted and answered by a single-cycle csr_rvalid_o pulse on the next cycle.
module pmp_csr_regfile
  import riscv_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_default,
  parameter int unsigned           NrEntries = CVA6Cfg.NrPMPEntries
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        csr_req_i,
  input  logic                        csr_we_i,
  input  logic [11:0]                 csr_addr_i,
  input  logic [31:0]                 csr_wdata_i,
  output logic                        csr_rvalid_o,
  output logic [31:0]                 csr_rdata_o,
  output logic                        csr_err_o,
  output pmpcfg_t [NrEntries-1:0]     pmpcfg_o,
  output logic [NrEntries-1:0][31:0]  pmpaddr_o
);

  logic                 w_is_cfg;
  logic                 w_is_addr;
  logic                 w_wr;
  logic [31:0]          w_rdata;
  logic [NrEntries:0]   w_tor_lock;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_err;

  assign w_is_cfg  = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
  assign w_is_addr = (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
  assign w_wr      = csr_req_i && csr_we_i;

  // The topmost implemented entry has no successor that could TOR-lock it.
  assign w_tor_lock[NrEntries] = 1'b0;

  for (genvar i = 0; i < NrEntries; i++) begin : g_entry
    pmp_entry_reg #(
      .CfgRstVal  (CVA6Cfg.PMPCfgRstVal[i][7:0]),
      .AddrRstVal (CVA6Cfg.PMPAddrRstVal[i][31:0]),
      .ReadOnly   (CVA6Cfg.PMPEntryReadOnly[i])
    ) u_entry (
      .i_clk           (clk_i),
      .i_rst_n         (rst_ni),
      .i_cfg_we        (w_wr && w_is_cfg && (csr_addr_i[1:0] == 2'(i / 4))),
      .i_cfg_wdata     (csr_wdata_i[8*(i%4) +: 8]),
      .i_addr_we       (w_wr && w_is_addr && (csr_addr_i[3:0] == 4'(i))),
      .i_addr_wdata    (csr_wdata_i),
      .i_next_tor_lock (w_tor_lock[i+1]),
      .o_cfg           (pmpcfg_o[i]),
      .o_addr          (pmpaddr_o[i]),
      .o_tor_lock      (w_tor_lock[i])
    );
  end

  // Unimplemented entries and non-PMP addresses fall through to zero.
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (w_is_cfg && (csr_addr_i[1:0] == 2'(i / 4))) begin
        w_rdata[8*(i%4) +: 8] = pmpcfg_o[i];
      end
      if (w_is_addr && (csr_addr_i[3:0] == 4'(i))) begin
        w_rdata = pmpaddr_o[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= csr_req_i;
      if (csr_req_i) begin
        r_rdata <= w_rdata;
        r_err   <= !(w_is_cfg || w_is_addr);
      end
    end
  end

  assign csr_rvalid_o = r_rvalid;
  assign csr_rdata_o  = r_rdata;
  assign csr_err_o    = r_err;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Bench for pmp_csr_regfile: two configurations driven in lockstep, directed
// steps then random CSR traffic, checked against an array-based PMP model.
module tb_pmp_csr_regfile;
  import riscv_pkg::*;

  function automatic config_pkg::cva6_cfg_t make_cfg_a();
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.NrPMPEntries     = 8;
    c.PMPCfgRstVal[0]  = 64'h9F;
    c.PMPCfgRstVal[2]  = 64'h6B;
    c.PMPAddrRstVal[3] = 64'h1234_5678;
    c.PMPAddrRstVal[6] = 64'hDEAD_BEEF;
    c.PMPEntryReadOnly = 16'h0008;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t CfgA = make_cfg_a();
  localparam config_pkg::cva6_cfg_t CfgB = config_pkg::cva6_cfg_default;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;

  logic rvalid_a, err_a, rvalid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic [7:0][7:0] cfg_a, cfg_b;
  logic [7:0][31:0] paddr_a, paddr_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_a, last_b;

  // Reference model state: [dut][entry]
  logic [7:0]  cfg_m [2][16];
  logic [31:0] addr_m[2][16];
  logic [15:0] ro_m  [2];

  always #5 clk = ~clk;

  pmp_csr_regfile #(.CVA6Cfg(CfgA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .csr_req_i(req), .csr_we_i(we),
    .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rvalid_o(rvalid_a),
    .csr_rdata_o(rdata_a), .csr_err_o(err_a), .pmpcfg_o(cfg_a), .pmpaddr_o(paddr_a)
  );

  pmp_csr_regfile #(.CVA6Cfg(CfgB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .csr_req_i(req), .csr_we_i(we),
    .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rvalid_o(rvalid_b),
    .csr_rdata_o(rdata_b), .csr_err_o(err_b), .pmpcfg_o(cfg_b), .pmpaddr_o(paddr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        cfg_m[d][i]  = 8'h00;
        addr_m[d][i] = 32'h0;
      end
    end
    cfg_m[0][0]  = 8'h9F;
    cfg_m[0][2]  = 8'h0B;
    addr_m[0][3] = 32'h1234_5678;
    addr_m[0][6] = 32'hDEAD_BEEF;
    ro_m[0] = 16'h0008;
    ro_m[1] = 16'h0000;
  endtask

  task automatic model_access(input int d, input logic w, input logic [11:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n, e;
    logic [7:0] b;
    rd = '0;
    er = 1'b0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      n = int'(a) - 'h3A0;
      for (int k = 0; k < 4; k++) begin
        e = 4 * n + k;
        if (e < NR) rd[8*k +: 8] = cfg_m[d][e];
      end
      if (w) begin
        for (int k = 0; k < 4; k++) begin
          e = 4 * n + k;
          b = wd[8*k +: 8];
          if (e < NR && !ro_m[d][e] && !cfg_m[d][e][7] && !(b[1] && !b[0]))
            cfg_m[d][e] = b & 8'h9F;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      n = int'(a) - 'h3B0;
      if (n < NR) begin
        rd = addr_m[d][n];
        if (w && !ro_m[d][n] && !cfg_m[d][n][7] &&
            !(n + 1 < NR && cfg_m[d][n+1][7] && cfg_m[d][n+1][4:3] == 2'b01))
          addr_m[d][n] = wd;
      end
    end else begin
      er = 1'b1;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("cfg_a[%0d]", i), {24'h0, cfg_a[i]}, {24'h0, cfg_m[0][i]});
      chk($sformatf("cfg_b[%0d]", i), {24'h0, cfg_b[i]}, {24'h0, cfg_m[1][i]});
      chk($sformatf("addr_a[%0d]", i), paddr_a[i], addr_m[0][i]);
      chk($sformatf("addr_b[%0d]", i), paddr_b[i], addr_m[1][i]);
    end
  endtask

  // Drive at a negedge; the response is checked at the following negedge.
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] rd0, rd1;
    logic e0, e1;
    model_access(0, w, a, wd, rd0, e0);
    model_access(1, w, a, wd, rd1, e1);
    exp_q.push_back(rd0);
    exp_q.push_back(rd1);
    req = 1'b1; we = w; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    last_a = rdata_a;
    last_b = rdata_b;
    chk($sformatf("rvalid_a@%h", a), {31'h0, rvalid_a}, 32'd1);
    chk($sformatf("rvalid_b@%h", a), {31'h0, rvalid_b}, 32'd1);
    chk($sformatf("rdata_a@%h", a), rdata_a, exp_q.pop_front());
    chk($sformatf("rdata_b@%h", a), rdata_b, exp_q.pop_front());
    chk($sformatf("err_a@%h", a), {31'h0, err_a}, {31'h0, e0});
    chk($sformatf("err_b@%h", a), {31'h0, err_b}, {31'h0, e1});
    check_outs();
  endtask

  task automatic idle();
    req = 1'b0;
    @(negedge clk);
    chk("rvalid_a_idle", {31'h0, rvalid_a}, 32'd0);
    chk("rvalid_b_idle", {31'h0, rvalid_b}, 32'd0);
  endtask

  task automatic check_reset_resp();
    chk("rst_rvalid_a", {31'h0, rvalid_a}, 32'd0);
    chk("rst_rvalid_b", {31'h0, rvalid_b}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    chk("rst_err_a", {31'h0, err_a}, 32'd0);
    chk("rst_err_b", {31'h0, err_b}, 32'd0);
    check_outs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    logic w;
    int r;

    // Clock/reset
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_resp();
    rst_n = 1'b1;

    // Reset values, bits 6:5 cleared on entry 2
    issue(1'b0, 12'h3A0, 32'h0);
    chk("tp_cfg0_rst_a", last_a, 32'h000B_009F);
    idle();

    // Reserved W=1,R=0 combination then a legal write
    issue(1'b1, 12'h3A0, 32'h0000_0002);
    issue(1'b0, 12'h3A0, 32'h0);
    chk("tp_warl_b", last_b, 32'h0000_0000);
    issue(1'b1, 12'h3A0, 32'h0000_0003);
    issue(1'b0, 12'h3A0, 32'h0);
    chk("tp_legal_b", last_b, 32'h0000_0003);

    // Entry 1 locked in TOR mode
    issue(1'b1, 12'h3A0, 32'h0000_8903);
    issue(1'b1, 12'h3B1, 32'h1111_1111);
    issue(1'b1, 12'h3B0, 32'h2000_0000);
    issue(1'b1, 12'h3A0, 32'h0000_0003);
    issue(1'b0, 12'h3A0, 32'h0);
    chk("tp_lock_cfg_b", last_b, 32'h0000_8903);
    issue(1'b0, 12'h3B0, 32'h0);
    chk("tp_tor_addr0_b", last_b, 32'h0);
    issue(1'b0, 12'h3B1, 32'h0);
    chk("tp_lock_addr1_b", last_b, 32'h0);

    // Unimplemented entries and non-PMP address
    issue(1'b1, 12'h3A2, 32'hFFFF_FFFF);
    issue(1'b0, 12'h3A2, 32'h0);
    chk("tp_cfg2_b", last_b, 32'h0);
    issue(1'b1, 12'h3BC, 32'hCAFE_F00D);
    issue(1'b0, 12'h3BC, 32'h0);
    chk("tp_addr12_a", last_a, 32'h0);
    issue(1'b1, 12'h3C0, 32'h5555_5555);
    chk("tp_err_a", {31'h0, err_a}, 32'd1);

    // Read-only entry 3
    issue(1'b1, 12'h3B3, 32'h0);
    issue(1'b0, 12'h3B3, 32'h0);
    chk("tp_ro_addr3_a", last_a, 32'h1234_5678);
    chk("tp_ro_out3_a", paddr_a[3], 32'h1234_5678);

    // Back-to-back csrrw to pmpaddr5
    issue(1'b1, 12'h3B5, 32'hAAAA_0001);
    issue(1'b1, 12'h3B5, 32'hBBBB_0002);
    chk("tp_b2b_old_b", last_b, 32'hAAAA_0001);
    chk("tp_b2b_out_b", paddr_b[5], 32'hBBBB_0002);
    idle();

    // Reset asserted mid-access: response dropped, state cleared
    req = 1'b1; we = 1'b1; addr = 12'h3B4; wdata = 32'h7777_7777;
    #2 rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0;
    model_reset();
    check_reset_resp();
    rst_n = 1'b1;
    issue(1'b0, 12'h3A0, 32'h0);
    chk("tp_unlock_b", last_b, 32'h0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if (n == 250) begin
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_resp();
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 21);
      if (r == 21) begin
        idle();
      end else begin
        if (r < 4) a = 12'h3A0 + 12'(r);
        else if (r < 20) a = 12'h3B0 + 12'(r - 4);
        else a = 12'($urandom_range(0, 4095));
        w = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
          for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 15) != 0) wd[8*k+7] = 1'b0;
          end
        end
        issue(w, a, wd);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
